// File: rtl/uart_tx_feeder.sv
// Byte FIFO and load sequencer feeding a UART transmitter on the baud clock.
// Define UART_TX_FEEDER_STATS_EN to add the sent_cnt/drop_cnt statistics outputs.
module uart_tx_feeder #(
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              txclk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  input  logic              tx_empty,
  output logic              ld_tx_data,
  output logic [7:0]        tx_data,
  output logic              tx_enable,
  output logic              busy,
  output logic              ack_err
`ifdef UART_TX_FEEDER_STATS_EN
  ,
  output logic [15:0]       sent_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0] ACK_TC = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

  logic [7:0]        mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              ld_q, ld_d, txen_q, txen_d, busy_q, busy_d, ack_err_q, ack_err_d;
  logic [7:0]        txd_q, txd_d, timer_q, timer_d;
  logic              push, pop;
`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0]       sent_q, sent_d, drop_q, drop_d;
`endif

  assign push = wr_en & ~full_q;
  assign pop  = (state_q == IDLE) & en & ~empty_q & tx_empty;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ld_d      = 1'b0;
    txd_d     = txd_q;
    timer_d   = timer_q;
    ack_err_d = ack_err_q;
    txen_d    = en;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    case (state_q)
      IDLE: if (pop) begin
        state_d = LOAD;
        ld_d    = 1'b1;
        txd_d   = mem[rd_ptr_q];
      end
      LOAD: begin
        timer_d = 8'd0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!tx_empty) begin
          state_d = WAIT_DONE;
        end else begin
          // Timeout fires on the edge the count reaches ACK_TIMEOUT, i.e.
          // ACK_TIMEOUT cycles after entering WAIT_ACK; the byte is abandoned.
          timer_d = timer_q + 8'd1;
          if (timer_d == ACK_TC) begin
            ack_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WAIT_DONE: if (tx_empty) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    full_d  = (level_d == LEVEL_MAX);
    empty_d = (level_d == '0);
    busy_d  = (state_d != IDLE);
  end

`ifdef UART_TX_FEEDER_STATS_EN
  always_comb begin
    sent_d = sent_q;
    drop_d = drop_q;
    if (state_q == WAIT_ACK && !tx_empty && sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
    if (wr_en && full_q && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end
`endif

  // Storage is not reset; pointers and level define validity.
  always_ff @(posedge txclk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ld_q      <= 1'b0;
      txd_q     <= 8'd0;
      txen_q    <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timer_q   <= 8'd0;
`ifdef UART_TX_FEEDER_STATS_EN
      sent_q    <= 16'd0;
      drop_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ld_q      <= ld_d;
      txd_q     <= txd_d;
      txen_q    <= txen_d;
      busy_q    <= busy_d;
      ack_err_q <= ack_err_d;
      timer_q   <= timer_d;
`ifdef UART_TX_FEEDER_STATS_EN
      sent_q    <= sent_d;
      drop_q    <= drop_d;
`endif
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
  assign ld_tx_data = ld_q;
  assign tx_data    = txd_q;
  assign tx_enable  = txen_q;
  assign busy       = busy_q;
  assign ack_err    = ack_err_q;
`ifdef UART_TX_FEEDER_STATS_EN
  assign sent_cnt   = sent_q;
  assign drop_cnt   = drop_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple transmitter model (depth-4 FIFO).
module tb_uart_tx_feeder;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int TO    = 15;

  logic txclk = 1'b0, reset = 1'b0, wr_en = 1'b0, en = 1'b0, tx_empty = 1'b1;
  logic [7:0] wr_data = 8'd0;
  logic full, empty, ld_tx_data, tx_enable, busy, ack_err;
  logic [AW:0] level;
  logic [7:0] tx_data;
`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] sent_cnt, drop_cnt;
`endif

  uart_tx_feeder #(.ADDR_W(AW), .ACK_TIMEOUT(TO)) dut (
    .txclk(txclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .en(en),
    .full(full), .empty(empty), .level(level), .tx_empty(tx_empty),
    .ld_tx_data(ld_tx_data), .tx_data(tx_data), .tx_enable(tx_enable),
    .busy(busy), .ack_err(ack_err)
`ifdef UART_TX_FEEDER_STATS_EN
    , .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 txclk = ~txclk;

  int n_checks = 0, n_fail = 0;
  logic [7:0] sb [$];
  int exp_level = 0, loads = 0, cnt = 0;
  logic pend = 1'b0, tie_high = 1'b0;
  logic [7:0] last_tx = 8'd0;

  // One clock cycle: scoreboard push before the edge, checks and transmitter model after it.
  task automatic tick();
    logic txe_before, busy_before, ld_before;
    logic [7:0] exp;
    txe_before  = tx_empty;
    busy_before = busy;
    ld_before   = ld_tx_data;
    if (wr_en && exp_level < DEPTH) begin
      sb.push_back(wr_data);
      exp_level++;
    end
    @(posedge txclk); #1;
    if (ld_tx_data) begin
      loads++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL unexpected_load tx_data=%h with empty scoreboard", tx_data);
      end else begin
        exp = sb.pop_front();
        exp_level--;
        n_checks++;
        if (tx_data !== exp) begin n_fail++; $display("FAIL tx_data got %h exp %h", tx_data, exp); end
      end
      n_checks++;
      if (txe_before !== 1'b1) begin n_fail++; $display("FAIL load_without_tx_empty got %b exp 1", txe_before); end
      n_checks++;
      if (ld_before) begin n_fail++; $display("FAIL double_load ld high two cycles got 1 exp 0"); end
      last_tx = tx_data;
    end else begin
      n_checks++;
      if (tx_data !== last_tx) begin n_fail++; $display("FAIL tx_data_hold got %h exp %h", tx_data, last_tx); end
    end
    n_checks++;
    if (level !== (AW+1)'(exp_level)) begin n_fail++; $display("FAIL level got %0d exp %0d", level, exp_level); end
    n_checks++;
    if (full !== (exp_level == DEPTH)) begin n_fail++; $display("FAIL full got %b exp %b", full, exp_level == DEPTH); end
    n_checks++;
    if (empty !== (exp_level == 0)) begin n_fail++; $display("FAIL empty got %b exp %b", empty, exp_level == 0); end
    if (busy_before && !busy) begin
      n_checks++;
      if (txe_before !== 1'b1) begin n_fail++; $display("FAIL busy_fall_early tx_empty got %b exp 1", txe_before); end
    end
    if (tie_high) tx_empty = 1'b1;
    else if (pend) begin tx_empty = 1'b0; cnt = 10; pend = 1'b0; end
    else if (cnt > 0) begin cnt--; if (cnt == 0) tx_empty = 1'b1; end
    if (ld_tx_data && !tie_high) pend = 1'b1;
  endtask

  task automatic write(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (!(busy == 1'b0 && exp_level == 0 && tx_empty && !pend && cnt == 0) && n < max) begin
      tick(); n++;
    end
    n_checks++;
    if (n >= max) begin n_fail++; $display("FAIL %s_timeout busy=%b level=%0d after %0d cycles", name, busy, level, n); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge txclk);
    #1;
    n_checks++;
    if ({level, empty, full, ld_tx_data, tx_data, tx_enable, busy, ack_err} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_values got lvl=%0d e=%b f=%b ld=%b d=%h te=%b b=%b ae=%b exp 0 1 0 0 00 0 0 0",
                         level, empty, full, ld_tx_data, tx_data, tx_enable, busy, ack_err);
    end
`ifdef UART_TX_FEEDER_STATS_EN
    n_checks++;
    if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stats got %0d %0d exp 0 0", sent_cnt, drop_cnt); end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int l0;
    en = 1'b1;
    tick();
    n_checks++;
    if (tx_enable !== 1'b1) begin n_fail++; $display("FAIL tx_enable got %b exp 1", tx_enable); end
    l0 = loads;
    write(8'h41);
    wait_idle(60, "single");
    n_checks++;
    if (loads - l0 !== 1) begin n_fail++; $display("FAIL single_loads got %0d exp 1", loads - l0); end
  endtask

  task automatic test_back_to_back();
    int l0 = loads;
    write(8'h48); write(8'h49); write(8'h0A);
    wait_idle(200, "burst");
    n_checks++;
    if (loads - l0 !== 3) begin n_fail++; $display("FAIL burst_loads got %0d exp 3", loads - l0); end
  endtask

  task automatic test_full();
    int l0;
`ifdef UART_TX_FEEDER_STATS_EN
    logic [15:0] s0, d0;
    s0 = sent_cnt; d0 = drop_cnt;
`endif
    en = 1'b0;
    tick(); tick();
    n_checks++;
    if (tx_enable !== 1'b0) begin n_fail++; $display("FAIL tx_enable_off got %b exp 0", tx_enable); end
    l0 = loads;
    for (int i = 0; i < 5; i++) write(8'hA0 + 8'(i));
    tick();
    n_checks++;
    if (full !== 1'b1 || level !== 3'd4 || loads != l0) begin
      n_fail++; $display("FAIL full_state got full=%b level=%0d loads=%0d exp 1 4 0", full, level, loads - l0);
    end
    en = 1'b1;
    wait_idle(300, "drain");
    n_checks++;
    if (loads - l0 !== 4) begin n_fail++; $display("FAIL drain_loads got %0d exp 4", loads - l0); end
`ifdef UART_TX_FEEDER_STATS_EN
    n_checks++;
    if (drop_cnt - d0 !== 16'd1) begin n_fail++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt - d0); end
    n_checks++;
    if (sent_cnt - s0 !== 16'd4) begin n_fail++; $display("FAIL sent_cnt got %0d exp 4", sent_cnt - s0); end
`endif
  endtask

  task automatic test_ack_timeout();
    int n = 0, l0 = loads;
    tie_high = 1'b1;
    write(8'h55);
    while (loads == l0 && n < 20) begin tick(); n++; end
    n_checks++;
    if (loads == l0) begin n_fail++; $display("FAIL ack_load_timeout no load after %0d cycles", n); end
    n = 0;
    while (!ack_err && n < 100) begin tick(); n++; end
    n_checks++;
    if (n !== TO + 1) begin n_fail++; $display("FAIL ack_err_delay got %0d cycles after load exp %0d", n, TO + 1); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ack_return_idle busy got %b exp 0", busy); end
    repeat (5) tick();
    n_checks++;
    if (ack_err !== 1'b1 || loads - l0 !== 1) begin
      n_fail++; $display("FAIL ack_sticky got ack_err=%b loads=%0d exp 1 1", ack_err, loads - l0);
    end
    tie_high = 1'b0;
  endtask

  task automatic test_simultaneous();
    int l0 = loads;
    en = 1'b0;
    write(8'hC1);
    tick();
    en = 1'b1; wr_en = 1'b1; wr_data = 8'hC2;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (ld_tx_data !== 1'b1 || level !== 3'd1) begin
      n_fail++; $display("FAIL simul_push_pop got ld=%b level=%0d exp 1 1", ld_tx_data, level);
    end
    wait_idle(100, "simul");
    n_checks++;
    if (loads - l0 !== 2) begin n_fail++; $display("FAIL simul_loads got %0d exp 2", loads - l0); end
  endtask

  task automatic test_reset_mid();
    int n = 0, l0;
    en = 1'b1;
    write(8'h31); write(8'h32); write(8'h33);
    while (tx_empty && n < 20) begin tick(); n++; end
    tick();
    n_checks++;
    if (busy !== 1'b1 || level !== 3'd2) begin n_fail++; $display("FAIL mid_setup got busy=%b level=%0d exp 1 2", busy, level); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({level, empty, full, ld_tx_data, tx_data, tx_enable, busy, ack_err} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset_values got lvl=%0d e=%b f=%b ld=%b d=%h te=%b b=%b ae=%b exp 0 1 0 0 00 0 0 0",
                         level, empty, full, ld_tx_data, tx_data, tx_enable, busy, ack_err);
    end
`ifdef UART_TX_FEEDER_STATS_EN
    n_checks++;
    if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset_stats got %0d %0d exp 0 0", sent_cnt, drop_cnt); end
`endif
    sb.delete(); exp_level = 0; last_tx = 8'd0;
    tx_empty = 1'b1; pend = 1'b0; cnt = 0;
    tick();
    reset = 1'b0;
    l0 = loads;
    repeat (20) tick();
    n_checks++;
    if (loads != l0) begin n_fail++; $display("FAIL load_after_reset got %0d loads exp 0", loads - l0); end
    write(8'h7E);
    wait_idle(60, "post_reset");
    n_checks++;
    if (loads - l0 !== 1) begin n_fail++; $display("FAIL post_reset_loads got %0d exp 1", loads - l0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_ack_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
